// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array sequencer.
// State encoding and memory read latency live here so every consumer agrees on them.
package sa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_STREAM  = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } sa_seq_state_t;

    // Cycles between a memory read request and its data being usable by the array.
    localparam int MEM_LAT = 1;

endpackage

// File: rtl/sa_addr_cnt.sv
// Saturating address up-counter with synchronous clear, enable and terminal flag.
// The count stops at N-1 so an address never wraps back to 0 mid-job.
module sa_addr_cnt #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         term_o
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_r;

    // Count register: clear has priority over enable, hold at the last address.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if (clr_i) begin
            cnt_r <= '0;
        end else if (en_i && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt_o  = cnt_r;
    assign term_o = (cnt_r == LAST);

endmodule

// File: rtl/sa_seq_ctrl.sv
// Job sequencer for a weight-stationary systolic array: preload weights, stream inputs, collect results.
// Optional cycle counter output perf_cycles_o is built when SA_SEQ_PERF_EN is defined.
module sa_seq_ctrl
    import sa_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ROW    = 3,
    parameter int COL    = 3,
    parameter int I_SIZE = 5,
    parameter int O_SIZE = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    output logic                       done_o,
    output logic                       busy_o,
    output logic                       wb_mem_cenb_o,
    output logic                       wb_mem_wenb_o,
    output logic [$clog2(ROW)-1:0]     wb_mem_addr_o,
    output logic                       ib_mem_cenb_o,
    output logic                       ib_mem_wenb_o,
    output logic [$clog2(I_SIZE)-1:0]  ib_mem_addr_o,
    output logic                       ob_mem_cenb_o,
    output logic                       ob_mem_wenb_o,
    output logic [$clog2(O_SIZE)-1:0]  ob_mem_addr_o,
    output logic [COL*WIDTH-1:0]       ob_mem_data_o,
    output logic                       sa_wload_o,
    output logic                       sa_ivalid_o,
    input  logic                       sa_ovalid_i,
    input  logic [COL*WIDTH-1:0]       sa_odata_i
`ifdef SA_SEQ_PERF_EN
    ,
    output logic [31:0]                perf_cycles_o
`endif
);

    localparam int WA_W = $clog2(ROW);
    localparam int IA_W = $clog2(I_SIZE);
    localparam int OA_W = $clog2(O_SIZE);

    sa_seq_state_t state_r, state_nxt_s;

    logic [WA_W-1:0] wcnt_s;
    logic [IA_W-1:0] icnt_s;
    logic [OA_W-1:0] ocnt_s;
    logic            wterm_s, iterm_s, oterm_s;
    logic            wclr_s, iclr_s, oclr_s;
    logic            accept_s;

    logic            wb_cenb_r, ib_cenb_r, ob_cenb_r, ob_wenb_r;
    logic [OA_W-1:0] ob_addr_r;
    logic [COL*WIDTH-1:0] ob_data_r;
    logic            done_r, busy_r, last_wr_r;
    logic [MEM_LAT-1:0] wload_pipe_r, ivalid_pipe_r;

    logic            wb_cenb_nxt_s, ib_cenb_nxt_s, ob_cenb_nxt_s, ob_wenb_nxt_s;
    logic [OA_W-1:0] ob_addr_nxt_s;
    logic [COL*WIDTH-1:0] ob_data_nxt_s;
    logic            done_nxt_s, busy_nxt_s, last_wr_nxt_s;
    logic [MEM_LAT-1:0] wload_pipe_nxt_s, ivalid_pipe_nxt_s;

    // A result row is taken only while results can arrive and fewer than O_SIZE have been taken.
    assign accept_s = sa_ovalid_i && !last_wr_r &&
                      ((state_r == ST_STREAM) || (state_r == ST_DRAIN));

    // Each address counter is held at zero whenever its phase is not (or no longer) active.
    assign wclr_s = (state_nxt_s != ST_PRELOAD);
    assign iclr_s = (state_nxt_s != ST_STREAM);
    assign oclr_s = (state_r == ST_IDLE) || (state_r == ST_DONE);

    sa_addr_cnt #(.N(ROW), .W(WA_W)) u_wcnt (
        .clk_i (clk_i), .rst_i (rst_i), .clr_i (wclr_s),
        .en_i  (state_r == ST_PRELOAD), .cnt_o (wcnt_s), .term_o (wterm_s)
    );

    sa_addr_cnt #(.N(I_SIZE), .W(IA_W)) u_icnt (
        .clk_i (clk_i), .rst_i (rst_i), .clr_i (iclr_s),
        .en_i  (state_r == ST_STREAM), .cnt_o (icnt_s), .term_o (iterm_s)
    );

    sa_addr_cnt #(.N(O_SIZE), .W(OA_W)) u_ocnt (
        .clk_i (clk_i), .rst_i (rst_i), .clr_i (oclr_s),
        .en_i  (accept_s), .cnt_o (ocnt_s), .term_o (oterm_s)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; completing the last result write ends the job even if streaming is unfinished.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:    state_nxt_s = start_i ? ST_PRELOAD : ST_IDLE;
            ST_PRELOAD: state_nxt_s = wterm_s ? ST_STREAM : ST_PRELOAD;
            ST_STREAM: begin
                if (last_wr_r) begin
                    state_nxt_s = ST_DONE;
                end else if (iterm_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_STREAM;
                end
            end
            ST_DRAIN:   state_nxt_s = last_wr_r ? ST_DONE : ST_DRAIN;
            ST_DONE:    state_nxt_s = ST_IDLE;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: next values for the output registers, decoded from the upcoming state.
    always_comb begin
        wb_cenb_nxt_s     = (state_nxt_s != ST_PRELOAD);
        ib_cenb_nxt_s     = (state_nxt_s != ST_STREAM);
        busy_nxt_s        = (state_nxt_s != ST_IDLE);
        done_nxt_s        = (state_nxt_s == ST_DONE);
        wload_pipe_nxt_s  = MEM_LAT'({wload_pipe_r, (state_r == ST_PRELOAD)});
        ivalid_pipe_nxt_s = MEM_LAT'({ivalid_pipe_r, (state_r == ST_STREAM)});
        ob_cenb_nxt_s     = !accept_s;
        ob_wenb_nxt_s     = !accept_s;
        if (accept_s) begin
            ob_addr_nxt_s = ocnt_s;
            ob_data_nxt_s = sa_odata_i;
        end else begin
            ob_addr_nxt_s = '0;
            ob_data_nxt_s = ob_data_r;
        end
        if (oclr_s) begin
            last_wr_nxt_s = 1'b0;
        end else begin
            last_wr_nxt_s = last_wr_r || (accept_s && oterm_s);
        end
    end

    // Output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_cenb_r     <= 1'b1;
            ib_cenb_r     <= 1'b1;
            ob_cenb_r     <= 1'b1;
            ob_wenb_r     <= 1'b1;
            ob_addr_r     <= '0;
            ob_data_r     <= '0;
            done_r        <= 1'b0;
            busy_r        <= 1'b0;
            last_wr_r     <= 1'b0;
            wload_pipe_r  <= '0;
            ivalid_pipe_r <= '0;
        end else begin
            wb_cenb_r     <= wb_cenb_nxt_s;
            ib_cenb_r     <= ib_cenb_nxt_s;
            ob_cenb_r     <= ob_cenb_nxt_s;
            ob_wenb_r     <= ob_wenb_nxt_s;
            ob_addr_r     <= ob_addr_nxt_s;
            ob_data_r     <= ob_data_nxt_s;
            done_r        <= done_nxt_s;
            busy_r        <= busy_nxt_s;
            last_wr_r     <= last_wr_nxt_s;
            wload_pipe_r  <= wload_pipe_nxt_s;
            ivalid_pipe_r <= ivalid_pipe_nxt_s;
        end
    end

    assign done_o        = done_r;
    assign busy_o        = busy_r;
    assign wb_mem_cenb_o = wb_cenb_r;
    assign wb_mem_wenb_o = 1'b1;
    assign wb_mem_addr_o = wcnt_s;
    assign ib_mem_cenb_o = ib_cenb_r;
    assign ib_mem_wenb_o = 1'b1;
    assign ib_mem_addr_o = icnt_s;
    assign ob_mem_cenb_o = ob_cenb_r;
    assign ob_mem_wenb_o = ob_wenb_r;
    assign ob_mem_addr_o = ob_addr_r;
    assign ob_mem_data_o = ob_data_r;
    assign sa_wload_o    = wload_pipe_r[MEM_LAT-1];
    assign sa_ivalid_o   = ivalid_pipe_r[MEM_LAT-1];

`ifdef SA_SEQ_PERF_EN
    logic [31:0] perf_r;

    // Job cycle counter: restarts on an accepted start and freezes once back in IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_r <= 32'd0;
        end else if (state_r == ST_IDLE) begin
            perf_r <= start_i ? 32'd0 : perf_r;
        end else begin
            perf_r <= perf_r + 32'd1;
        end
    end

    assign perf_cycles_o = perf_r;
`endif

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Self-checking bench for sa_seq_ctrl: cycle-schedule table, result-write scoreboard, mid-job reset.
module tb_sa_seq_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        done_o, busy_o;
    logic        wb_mem_cenb_o, wb_mem_wenb_o;
    logic [1:0]  wb_mem_addr_o;
    logic        ib_mem_cenb_o, ib_mem_wenb_o;
    logic [2:0]  ib_mem_addr_o;
    logic        ob_mem_cenb_o, ob_mem_wenb_o;
    logic [2:0]  ob_mem_addr_o;
    logic [23:0] ob_mem_data_o;
    logic        sa_wload_o, sa_ivalid_o;
    logic        sa_ovalid_i = 1'b0;
    logic [23:0] sa_odata_i = 24'h0;
`ifdef SA_SEQ_PERF_EN
    logic [31:0] perf_cycles_o;
`endif

    sa_seq_ctrl #(.WIDTH(8), .ROW(3), .COL(3), .I_SIZE(5), .O_SIZE(5)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .done_o        (done_o),
        .busy_o        (busy_o),
        .wb_mem_cenb_o (wb_mem_cenb_o),
        .wb_mem_wenb_o (wb_mem_wenb_o),
        .wb_mem_addr_o (wb_mem_addr_o),
        .ib_mem_cenb_o (ib_mem_cenb_o),
        .ib_mem_wenb_o (ib_mem_wenb_o),
        .ib_mem_addr_o (ib_mem_addr_o),
        .ob_mem_cenb_o (ob_mem_cenb_o),
        .ob_mem_wenb_o (ob_mem_wenb_o),
        .ob_mem_addr_o (ob_mem_addr_o),
        .ob_mem_data_o (ob_mem_data_o),
        .sa_wload_o    (sa_wload_o),
        .sa_ivalid_o   (sa_ivalid_o),
        .sa_ovalid_i   (sa_ovalid_i),
        .sa_odata_i    (sa_odata_i)
`ifdef SA_SEQ_PERF_EN
        ,
        .perf_cycles_o (perf_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       wb_cenb;
        logic [1:0] wb_addr;
        logic       wload;
        logic       ib_cenb;
        logic [2:0] ib_addr;
        logic       ivalid;
        logic       busy;
    } vec_t;

    typedef struct {
        logic [2:0]  addr;
        logic [23:0] data;
        int          cyc;
    } wr_t;

    vec_t        tbl[11];
    wr_t         exp_q[$];
    int          pc[5];
    logic [23:0] pd[5];
    int          errors = 0;
    int          checks = 0;
    int          cyc_g  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_wb_cenb"}, 64'(wb_mem_cenb_o), 64'd1);
        chk({tag, "_wb_wenb"}, 64'(wb_mem_wenb_o), 64'd1);
        chk({tag, "_wb_addr"}, 64'(wb_mem_addr_o), 64'd0);
        chk({tag, "_ib_cenb"}, 64'(ib_mem_cenb_o), 64'd1);
        chk({tag, "_ib_wenb"}, 64'(ib_mem_wenb_o), 64'd1);
        chk({tag, "_ib_addr"}, 64'(ib_mem_addr_o), 64'd0);
        chk({tag, "_ob_cenb"}, 64'(ob_mem_cenb_o), 64'd1);
        chk({tag, "_ob_wenb"}, 64'(ob_mem_wenb_o), 64'd1);
        chk({tag, "_ob_addr"}, 64'(ob_mem_addr_o), 64'd0);
        chk({tag, "_ob_data"}, 64'(ob_mem_data_o), 64'd0);
        chk({tag, "_done"},    64'(done_o),        64'd0);
        chk({tag, "_busy"},    64'(busy_o),        64'd0);
        chk({tag, "_wload"},   64'(sa_wload_o),    64'd0);
        chk({tag, "_ivalid"},  64'(sa_ivalid_o),   64'd0);
    endtask

    // Scoreboard: every output-memory write must match the oldest expected write, including its cycle.
    always @(negedge clk_i) begin
        if (!rst_i && (ob_mem_cenb_o == 1'b0) && (ob_mem_wenb_o == 1'b0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ob_unexpected_write: got addr %0h data %0h at cycle %0d required no write",
                         ob_mem_addr_o, ob_mem_data_o, cyc_g);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("ob_addr", 64'(ob_mem_addr_o), 64'(e.addr));
                chk("ob_data", 64'(ob_mem_data_o), 64'(e.data));
                chk("ob_cycle", 64'(cyc_g), 64'(e.cyc));
            end
        end
    end

    // One full job starting in cycle 0, with ignored start/ovalid stimulus in the wrong states.
    task automatic run_job(input string tag);
        for (int c = 0; c <= 21; c++) begin
            start_i     = (c == 0) || (c == 6);
            sa_ovalid_i = 1'b0;
            sa_odata_i  = 24'h0;
            if (c == 2 || c == 18 || c == 19) begin
                sa_ovalid_i = 1'b1;
                sa_odata_i  = 24'hEEEEEE;
            end
            for (int p = 0; p < 5; p++) begin
                if (c == pc[p]) begin
                    wr_t w;
                    sa_ovalid_i = 1'b1;
                    sa_odata_i  = pd[p];
                    w.addr = 3'(p);
                    w.data = pd[p];
                    w.cyc  = c + 1;
                    exp_q.push_back(w);
                end
            end
            cyc_g = c;
            @(negedge clk_i);
            if (c <= 10) begin
                chk($sformatf("%s_c%0d_wb_cenb", tag, c), 64'(wb_mem_cenb_o), 64'(tbl[c].wb_cenb));
                chk($sformatf("%s_c%0d_wb_addr", tag, c), 64'(wb_mem_addr_o), 64'(tbl[c].wb_addr));
                chk($sformatf("%s_c%0d_wload",   tag, c), 64'(sa_wload_o),    64'(tbl[c].wload));
                chk($sformatf("%s_c%0d_ib_cenb", tag, c), 64'(ib_mem_cenb_o), 64'(tbl[c].ib_cenb));
                chk($sformatf("%s_c%0d_ib_addr", tag, c), 64'(ib_mem_addr_o), 64'(tbl[c].ib_addr));
                chk($sformatf("%s_c%0d_ivalid",  tag, c), 64'(sa_ivalid_o),   64'(tbl[c].ivalid));
                chk($sformatf("%s_c%0d_busy",    tag, c), 64'(busy_o),        64'(tbl[c].busy));
            end
            if (c >= 17 && c <= 20) begin
                chk($sformatf("%s_c%0d_done", tag, c), 64'(done_o), 64'(c == 19));
                chk($sformatf("%s_c%0d_busy", tag, c), 64'(busy_o), 64'(c != 20));
            end
`ifdef SA_SEQ_PERF_EN
            if (c == 20) begin
                chk({tag, "_perf_cycles"}, 64'(perf_cycles_o), 64'd19);
            end
`endif
            @(posedge clk_i);
            #1;
        end
        start_i     = 1'b0;
        sa_ovalid_i = 1'b0;
        chk({tag, "_ob_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            wb_cenb wb_addr wload ib_cenb ib_addr ivalid busy
        tbl[0]  = '{1'b1, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 2'd1, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 2'd2, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 2'd0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 2'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1};
        tbl[6]  = '{1'b1, 2'd0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 2'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 2'd0, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 2'd0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 2'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
        pc = '{11, 12, 14, 15, 17};
        pd = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C, 24'h0D0E0F};

        // Power-on reset.
        @(negedge clk_i);
        check_reset("por");
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        run_job("job1");

        // Start a job, then reset it while streaming.
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk("mid_c5_busy",    64'(busy_o),        64'd1);
        chk("mid_c5_ib_cenb", 64'(ib_mem_cenb_o), 64'd0);
        chk("mid_c5_ib_addr", 64'(ib_mem_addr_o), 64'd1);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check_reset("midrst");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        run_job("job2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
